// File: rtl/flood_game_ctrl.sv
// flood_game_ctrl
// Game-side controller that sits between the menu/select block and the board
// (flood-fill) engine. It acknowledges a begin-game request and latches the
// game settings, acknowledges every colour-select request, launches exactly one
// flood fill per legal move, counts tries and declares a win or a loss. A fill
// that never completes is caught by a watchdog and ends the game as lost.
//
// Ports
//   MASTER_CLOCK             in   system clock, the only clock
//   RESET_N                  in   async active-low reset
//   BEGIN_GAME               in   level begin-game request from select
//   ACK_BEGIN_GAME           out  begin-game acknowledge
//   final_SIZE               in   board size, latched at game start
//   final_COLOR_NUM          in   colour count, latched at game start
//   TOTAL_TRIES              in   move budget, latched at game start
//   COLOR_SEL_SIG            in   level move request
//   COLOR_SELECTED           in   requested colour (valid with COLOR_SEL_SIG)
//   CURRENTLY_CHANGING_COLOR out  move acknowledge / busy
//   CURRENT_COLOR            in   colour of the top-left cell
//   FILL_START               out  1-cycle flood-fill start pulse
//   FILL_COLOR               out  fill colour, stable for the whole fill
//   FILL_DONE                in   1-cycle fill-complete pulse
//   FILL_ALL_SAME            in   board uniform, valid with FILL_DONE
//   TRIES                    out  legal moves made this game (saturating)
//   IN_GAME                  out  game in progress
//   GAME_WON / GAME_LOST     out  end-of-game flags
//   FILL_FAULT               out  sticky fill-timeout flag

module flood_game_ctrl #(
  parameter int TRIES_W      = 8,
  parameter int FILL_TIMEOUT = 1000000
) (
  input  logic               MASTER_CLOCK,
  input  logic               RESET_N,
  input  logic               BEGIN_GAME,
  output logic               ACK_BEGIN_GAME,
  input  logic [4:0]         final_SIZE,
  input  logic [3:0]         final_COLOR_NUM,
  input  logic [TRIES_W-1:0] TOTAL_TRIES,
  input  logic               COLOR_SEL_SIG,
  input  logic [2:0]         COLOR_SELECTED,
  output logic               CURRENTLY_CHANGING_COLOR,
  input  logic [2:0]         CURRENT_COLOR,
  output logic               FILL_START,
  output logic [2:0]         FILL_COLOR,
  input  logic               FILL_DONE,
  input  logic               FILL_ALL_SAME,
  output logic [TRIES_W-1:0] TRIES,
  output logic               IN_GAME,
  output logic               GAME_WON,
  output logic               GAME_LOST,
  output logic               FILL_FAULT
);

  localparam int TMR_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FILL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PLAY,
    S_CHECK,
    S_FILL,
    S_WAIT_DROP,
    S_WON,
    S_LOST
  } state_t;

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic               ccc_q, ccc_d;
  logic               fill_start_q, fill_start_d;
  logic [2:0]         fill_color_q, fill_color_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               won_q, won_d;
  logic               lost_q, lost_d;
  logic               fault_q, fault_d;
  logic               in_game_q, in_game_d;
  // Board size travels with the other settings but nothing here consumes it.
  logic [4:0]         unused_size_q, unused_size_d;
  logic [3:0]         colnum_q, colnum_d;
  logic [TRIES_W-1:0] total_q, total_d;
  logic [2:0]         sel_q, sel_d;
  logic               won_pend_q, won_pend_d;
  logic               lost_pend_q, lost_pend_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;

  logic               take_begin;
  logic               move_illegal;
  logic [TRIES_W-1:0] tries_inc;

  // A new game may only start from a settled state; during a move the
  // request is left pending and served once the move returns to PLAY.
  assign take_begin   = BEGIN_GAME &&
                        (state_q inside {S_IDLE, S_PLAY, S_WON, S_LOST});
  assign move_illegal = ({1'b0, sel_q} >= colnum_q) || (sel_q == CURRENT_COLOR);
  assign tries_inc    = (&tries_q) ? tries_q : tries_q + TRIES_W'(1);

  // NOTE: every variable gets its hold value first so that no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    ack_d         = ack_q;
    ccc_d         = ccc_q;
    fill_start_d  = 1'b0;
    fill_color_d  = fill_color_q;
    tries_d       = tries_q;
    won_d         = won_q;
    lost_d        = lost_q;
    fault_d       = fault_q;
    unused_size_d = unused_size_q;
    colnum_d      = colnum_q;
    total_d       = total_q;
    sel_d         = sel_q;
    won_pend_d    = won_pend_q;
    lost_pend_d   = lost_pend_q;
    tmr_d         = tmr_q;

    if (take_begin) begin
      state_d       = S_START;
      ack_d         = 1'b1;
      unused_size_d = final_SIZE;
      colnum_d      = final_COLOR_NUM;
      total_d       = TOTAL_TRIES;
      tries_d       = '0;
      won_d         = 1'b0;
      lost_d        = 1'b0;
      // A select level still being acked keeps its ack until it drops.
      ccc_d         = ccc_q & COLOR_SEL_SIG;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_START: begin
          ccc_d = ccc_q & COLOR_SEL_SIG;
          if (!BEGIN_GAME) begin
            ack_d   = 1'b0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          // A request counts only on a fresh level (ack low), so one held
          // level can never launch a second fill.
          if (COLOR_SEL_SIG && !ccc_q) begin
            ccc_d       = 1'b1;
            sel_d       = COLOR_SELECTED;
            won_pend_d  = 1'b0;
            lost_pend_d = 1'b0;
            state_d     = S_CHECK;
          end else if (!COLOR_SEL_SIG) begin
            ccc_d = 1'b0;
          end
        end
        S_CHECK: begin
          if (move_illegal) begin
            state_d = S_WAIT_DROP;
          end else begin
            fill_start_d = 1'b1;
            fill_color_d = sel_q;
            tries_d      = tries_inc;
            tmr_d        = '0;
            state_d      = S_FILL;
          end
        end
        S_FILL: begin
          if (FILL_DONE) begin
            // A uniform board wins even when the budget is exhausted.
            won_pend_d  = FILL_ALL_SAME;
            lost_pend_d = !FILL_ALL_SAME && (tries_q >= total_q);
            state_d     = S_WAIT_DROP;
          end else if (tmr_q == TMR_LAST) begin
            fault_d = 1'b1;
            lost_d  = 1'b1;
            ccc_d   = 1'b0;
            state_d = S_LOST;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_WAIT_DROP: begin
          if (!COLOR_SEL_SIG) begin
            ccc_d = 1'b0;
            if (won_pend_q) begin
              won_d   = 1'b1;
              state_d = S_WON;
            end else if (lost_pend_q) begin
              lost_d  = 1'b1;
              state_d = S_LOST;
            end else begin
              state_d = S_PLAY;
            end
          end
        end
        S_WON, S_LOST: begin
          // Requests after the game ends are acked but never filled.
          ccc_d = COLOR_SEL_SIG;
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_game_d = state_d inside {S_PLAY, S_CHECK, S_FILL, S_WAIT_DROP};
  end

  // NOTE: every register here, including the latched settings, is cleared by
  // the async reset so a reset mid-fill drops all handshakes immediately.
  // NOTE: non-blocking assignments keep every register sampling the values
  // from before the edge, independent of statement order.
  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      ack_q         <= 1'b0;
      ccc_q         <= 1'b0;
      fill_start_q  <= 1'b0;
      fill_color_q  <= '0;
      tries_q       <= '0;
      won_q         <= 1'b0;
      lost_q        <= 1'b0;
      fault_q       <= 1'b0;
      in_game_q     <= 1'b0;
      unused_size_q <= '0;
      colnum_q      <= '0;
      total_q       <= '0;
      sel_q         <= '0;
      won_pend_q    <= 1'b0;
      lost_pend_q   <= 1'b0;
      tmr_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      ccc_q         <= ccc_d;
      fill_start_q  <= fill_start_d;
      fill_color_q  <= fill_color_d;
      tries_q       <= tries_d;
      won_q         <= won_d;
      lost_q        <= lost_d;
      fault_q       <= fault_d;
      in_game_q     <= in_game_d;
      unused_size_q <= unused_size_d;
      colnum_q      <= colnum_d;
      total_q       <= total_d;
      sel_q         <= sel_d;
      won_pend_q    <= won_pend_d;
      lost_pend_q   <= lost_pend_d;
      tmr_q         <= tmr_d;
    end
  end

  assign ACK_BEGIN_GAME           = ack_q;
  assign CURRENTLY_CHANGING_COLOR = ccc_q;
  assign FILL_START               = fill_start_q;
  assign FILL_COLOR               = fill_color_q;
  assign TRIES                    = tries_q;
  assign IN_GAME                  = in_game_q;
  assign GAME_WON                 = won_q;
  assign GAME_LOST                = lost_q;
  assign FILL_FAULT               = fault_q;

endmodule

// File: tb/tb_flood_game_ctrl.sv
// Testbench for flood_game_ctrl. Stimulus comes from per-scenario tasks that
// play the select block and the board engine. Expected fill colours are
// queued when a legal move is issued and popped by a monitor whenever the
// controller emits FILL_START.

module tb_flood_game_ctrl;

  localparam int TW = 8;
  localparam int TO = 200;

  logic          MASTER_CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          BEGIN_GAME = 1'b0;
  logic          ACK_BEGIN_GAME;
  logic [4:0]    final_SIZE = '0;
  logic [3:0]    final_COLOR_NUM = '0;
  logic [TW-1:0] TOTAL_TRIES = '0;
  logic          COLOR_SEL_SIG = 1'b0;
  logic [2:0]    COLOR_SELECTED = '0;
  logic          CURRENTLY_CHANGING_COLOR;
  logic [2:0]    CURRENT_COLOR = '0;
  logic          FILL_START;
  logic [2:0]    FILL_COLOR;
  logic          FILL_DONE = 1'b0;
  logic          FILL_ALL_SAME = 1'b0;
  logic [TW-1:0] TRIES;
  logic          IN_GAME;
  logic          GAME_WON;
  logic          GAME_LOST;
  logic          FILL_FAULT;

  int         n_checks = 0;
  int         n_pass = 0;
  int         fill_cnt = 0;
  logic [2:0] exp_fill_q[$];
  logic [2:0] mon_exp;

  flood_game_ctrl #(.TRIES_W(TW), .FILL_TIMEOUT(TO)) dut (
    .MASTER_CLOCK             (MASTER_CLOCK),
    .RESET_N                  (RESET_N),
    .BEGIN_GAME               (BEGIN_GAME),
    .ACK_BEGIN_GAME           (ACK_BEGIN_GAME),
    .final_SIZE               (final_SIZE),
    .final_COLOR_NUM          (final_COLOR_NUM),
    .TOTAL_TRIES              (TOTAL_TRIES),
    .COLOR_SEL_SIG            (COLOR_SEL_SIG),
    .COLOR_SELECTED           (COLOR_SELECTED),
    .CURRENTLY_CHANGING_COLOR (CURRENTLY_CHANGING_COLOR),
    .CURRENT_COLOR            (CURRENT_COLOR),
    .FILL_START               (FILL_START),
    .FILL_COLOR               (FILL_COLOR),
    .FILL_DONE                (FILL_DONE),
    .FILL_ALL_SAME            (FILL_ALL_SAME),
    .TRIES                    (TRIES),
    .IN_GAME                  (IN_GAME),
    .GAME_WON                 (GAME_WON),
    .GAME_LOST                (GAME_LOST),
    .FILL_FAULT               (FILL_FAULT)
  );

  always #5 MASTER_CLOCK = ~MASTER_CLOCK;

  // Scoreboard side: every FILL_START cycle must match a queued legal move.
  always @(negedge MASTER_CLOCK) begin
    if (RESET_N && FILL_START) begin
      fill_cnt++;
      n_checks++;
      if (exp_fill_q.size() == 0) begin
        $display("FAIL fill_unexpected: FILL_START=1 FILL_COLOR=%0d, no fill expected", FILL_COLOR);
      end else begin
        mon_exp = exp_fill_q.pop_front();
        if (FILL_COLOR !== mon_exp)
          $display("FAIL fill_color: got %0d expected %0d", FILL_COLOR, mon_exp);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(negedge MASTER_CLOCK);
    #1;
  endtask

  task automatic wait_ccc(input logic val, input string name);
    for (int i = 0; i < 20; i++) begin
      if (CURRENTLY_CHANGING_COLOR === val) break;
      tick();
    end
    n_checks++;
    if (CURRENTLY_CHANGING_COLOR !== val)
      $display("FAIL %s: CURRENTLY_CHANGING_COLOR got %b expected %b", name, CURRENTLY_CHANGING_COLOR, val);
    else
      n_pass++;
  endtask

  task automatic wait_fill(input int start_cnt, input string name);
    for (int i = 0; i < 10; i++) begin
      if (fill_cnt != start_cnt) break;
      tick();
    end
    n_checks++;
    if (fill_cnt == start_cnt)
      $display("FAIL %s: no FILL_START within 10 cycles, got 0 expected 1", name);
    else
      n_pass++;
  endtask

  task automatic start_game(input logic [4:0] size, input logic [3:0] cnum,
                            input logic [TW-1:0] total, input string name);
    final_SIZE      = size;
    final_COLOR_NUM = cnum;
    TOTAL_TRIES     = total;
    BEGIN_GAME      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ACK_BEGIN_GAME === 1'b1) break;
      tick();
    end
    BEGIN_GAME = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ACK_BEGIN_GAME === 1'b0) break;
      tick();
    end
    n_checks++;
    if ({ACK_BEGIN_GAME, IN_GAME, TRIES, GAME_WON, GAME_LOST} !== {1'b0, 1'b1, {TW{1'b0}}, 1'b0, 1'b0})
      $display("FAIL %s: ack/in_game/tries/won/lost got %b/%b/%0d/%b/%b expected 0/1/0/0/0",
               name, ACK_BEGIN_GAME, IN_GAME, TRIES, GAME_WON, GAME_LOST);
    else
      n_pass++;
  endtask

  // One complete select-block move plus board-engine response.
  task automatic do_move(input logic [2:0] sel, input bit legal, input bit all_same,
                         input int delay, input logic [TW-1:0] exp_tries,
                         input logic exp_won, input logic exp_lost, input string name);
    int start_cnt;
    start_cnt      = fill_cnt;
    COLOR_SELECTED = sel;
    COLOR_SEL_SIG  = 1'b1;
    if (legal) exp_fill_q.push_back(sel);
    wait_ccc(1'b1, {name, "_ack"});
    if (legal) begin
      wait_fill(start_cnt, {name, "_fill"});
      repeat (delay) tick();
      FILL_DONE     = 1'b1;
      FILL_ALL_SAME = all_same;
      tick();
      FILL_DONE     = 1'b0;
      FILL_ALL_SAME = 1'b0;
      CURRENT_COLOR = sel;
    end else begin
      repeat (3) tick();
      n_checks++;
      if (fill_cnt != start_cnt)
        $display("FAIL %s_nofill: fills got %0d expected %0d", name, fill_cnt, start_cnt);
      else
        n_pass++;
    end
    repeat (4) tick();
    n_checks++;
    if (CURRENTLY_CHANGING_COLOR !== 1'b1)
      $display("FAIL %s_hold: CURRENTLY_CHANGING_COLOR got %b expected 1", name, CURRENTLY_CHANGING_COLOR);
    else
      n_pass++;
    COLOR_SEL_SIG = 1'b0;
    wait_ccc(1'b0, {name, "_release"});
    n_checks++;
    if ({TRIES, GAME_WON, GAME_LOST} !== {exp_tries, exp_won, exp_lost})
      $display("FAIL %s_result: tries/won/lost got %0d/%b/%b expected %0d/%b/%b",
               name, TRIES, GAME_WON, GAME_LOST, exp_tries, exp_won, exp_lost);
    else
      n_pass++;
    tick();
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, FILL_START, FILL_COLOR, TRIES,
         IN_GAME, GAME_WON, GAME_LOST, FILL_FAULT} !== '0)
      $display("FAIL %s: outputs ack=%b ccc=%b fs=%b fc=%0d tries=%0d ig=%b w=%b l=%b ff=%b expected all 0",
               name, ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, FILL_START, FILL_COLOR, TRIES,
               IN_GAME, GAME_WON, GAME_LOST, FILL_FAULT);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    RESET_N = 1'b1;
    repeat (2) tick();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_begin();
    final_SIZE      = 5'd14;
    final_COLOR_NUM = 4'd6;
    TOTAL_TRIES     = 8'd25;
    CURRENT_COLOR   = 3'd2;
    BEGIN_GAME      = 1'b1;
    tick();
    n_checks++;
    if ({ACK_BEGIN_GAME, IN_GAME} !== 2'b10)
      $display("FAIL begin_ack_rise: ack/in_game got %b/%b expected 1/0", ACK_BEGIN_GAME, IN_GAME);
    else
      n_pass++;
    repeat (4) tick();
    n_checks++;
    if (ACK_BEGIN_GAME !== 1'b1)
      $display("FAIL begin_ack_hold: got %b expected 1", ACK_BEGIN_GAME);
    else
      n_pass++;
    BEGIN_GAME = 1'b0;
    tick();
    n_checks++;
    if ({ACK_BEGIN_GAME, IN_GAME, TRIES} !== {1'b0, 1'b1, 8'd0})
      $display("FAIL begin_ack_fall: ack/in_game/tries got %b/%b/%0d expected 0/1/0",
               ACK_BEGIN_GAME, IN_GAME, TRIES);
    else
      n_pass++;
  endtask

  task automatic test_legal_fill();
    do_move(3'd4, 1'b1, 1'b0, 50, 8'd1, 1'b0, 1'b0, "legal_fill");
  endtask

  task automatic test_illegal();
    CURRENT_COLOR = 3'd2;
    do_move(3'd2, 1'b0, 1'b0, 0, 8'd1, 1'b0, 1'b0, "illegal_same");
    do_move(3'd7, 1'b0, 1'b0, 0, 8'd1, 1'b0, 1'b0, "illegal_range7");
    do_move(3'd6, 1'b0, 1'b0, 0, 8'd1, 1'b0, 1'b0, "illegal_range6");
    do_move(3'd5, 1'b1, 1'b0, 5, 8'd2, 1'b0, 1'b0, "legal_edge5");
  endtask

  task automatic test_lost();
    start_game(5'd14, 4'd6, 8'd3, "lost_start");
    CURRENT_COLOR = 3'd2;
    do_move(3'd4, 1'b1, 1'b0, 3, 8'd1, 1'b0, 1'b0, "lost_m1");
    do_move(3'd1, 1'b1, 1'b0, 3, 8'd2, 1'b0, 1'b0, "lost_m2");
    do_move(3'd3, 1'b1, 1'b0, 3, 8'd3, 1'b0, 1'b1, "lost_m3");
    do_move(3'd5, 1'b0, 1'b0, 0, 8'd3, 1'b0, 1'b1, "lost_after");
  endtask

  task automatic test_won();
    start_game(5'd14, 4'd6, 8'd3, "won_start");
    CURRENT_COLOR = 3'd2;
    do_move(3'd4, 1'b1, 1'b0, 3, 8'd1, 1'b0, 1'b0, "won_m1");
    do_move(3'd1, 1'b1, 1'b0, 3, 8'd2, 1'b0, 1'b0, "won_m2");
    do_move(3'd3, 1'b1, 1'b1, 3, 8'd3, 1'b1, 1'b0, "won_m3");
    do_move(3'd0, 1'b0, 1'b0, 0, 8'd3, 1'b1, 1'b0, "won_after");
  endtask

  task automatic test_zero_budget();
    start_game(5'd2, 4'd3, 8'd0, "zero_start");
    CURRENT_COLOR = 3'd0;
    do_move(3'd1, 1'b1, 1'b0, 2, 8'd1, 1'b0, 1'b1, "zero_m1");
  endtask

  task automatic test_timeout();
    int start_cnt;
    start_game(5'd26, 4'd8, 8'd25, "to_start");
    CURRENT_COLOR  = 3'd0;
    start_cnt      = fill_cnt;
    COLOR_SELECTED = 3'd7;
    COLOR_SEL_SIG  = 1'b1;
    exp_fill_q.push_back(3'd7);
    wait_ccc(1'b1, "to_ack");
    wait_fill(start_cnt, "to_fill");
    repeat (TO - 5) tick();
    n_checks++;
    if (FILL_FAULT !== 1'b0)
      $display("FAIL to_early: FILL_FAULT got %b expected 0", FILL_FAULT);
    else
      n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (FILL_FAULT === 1'b1) break;
      tick();
    end
    n_checks++;
    if ({FILL_FAULT, GAME_LOST, CURRENTLY_CHANGING_COLOR, IN_GAME} !== 4'b1100)
      $display("FAIL to_fault: fault/lost/ccc/in_game got %b/%b/%b/%b expected 1/1/0/0",
               FILL_FAULT, GAME_LOST, CURRENTLY_CHANGING_COLOR, IN_GAME);
    else
      n_pass++;
    COLOR_SEL_SIG = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_fill();
    int start_cnt;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    start_game(5'd10, 4'd5, 8'd25, "rst_start");
    CURRENT_COLOR  = 3'd0;
    start_cnt      = fill_cnt;
    COLOR_SELECTED = 3'd3;
    COLOR_SEL_SIG  = 1'b1;
    exp_fill_q.push_back(3'd3);
    wait_ccc(1'b1, "rst_ack");
    wait_fill(start_cnt, "rst_fill");
    repeat (5) tick();
    #2;
    RESET_N = 1'b0;
    #1;
    check_all_zero("reset_mid_fill");
    COLOR_SEL_SIG = 1'b0;
    tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    check_all_zero("idle_after_mid_reset");
  endtask

  task automatic test_begin_during_fill();
    int start_cnt;
    start_game(5'd14, 4'd6, 8'd25, "bdf_start");
    CURRENT_COLOR  = 3'd2;
    start_cnt      = fill_cnt;
    COLOR_SELECTED = 3'd4;
    COLOR_SEL_SIG  = 1'b1;
    exp_fill_q.push_back(3'd4);
    wait_ccc(1'b1, "bdf_ack");
    wait_fill(start_cnt, "bdf_fill");
    BEGIN_GAME = 1'b1;
    repeat (10) tick();
    n_checks++;
    if ({ACK_BEGIN_GAME, TRIES} !== {1'b0, 8'd1})
      $display("FAIL bdf_ignored: ack/tries got %b/%0d expected 0/1", ACK_BEGIN_GAME, TRIES);
    else
      n_pass++;
    FILL_DONE = 1'b1;
    tick();
    FILL_DONE     = 1'b0;
    CURRENT_COLOR = 3'd4;
    repeat (3) tick();
    n_checks++;
    if ({ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR} !== 2'b01)
      $display("FAIL bdf_wait_drop: ack/ccc got %b/%b expected 0/1", ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR);
    else
      n_pass++;
    COLOR_SEL_SIG = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ACK_BEGIN_GAME === 1'b1) break;
      tick();
    end
    n_checks++;
    if ({ACK_BEGIN_GAME, TRIES, GAME_WON, GAME_LOST, CURRENTLY_CHANGING_COLOR} !== {1'b1, 8'd0, 3'b000})
      $display("FAIL bdf_restart: ack/tries/won/lost/ccc got %b/%0d/%b/%b/%b expected 1/0/0/0/0",
               ACK_BEGIN_GAME, TRIES, GAME_WON, GAME_LOST, CURRENTLY_CHANGING_COLOR);
    else
      n_pass++;
    BEGIN_GAME = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({ACK_BEGIN_GAME, IN_GAME} !== 2'b01)
      $display("FAIL bdf_play: ack/in_game got %b/%b expected 0/1", ACK_BEGIN_GAME, IN_GAME);
    else
      n_pass++;
  endtask

  task automatic test_back_to_back();
    CURRENT_COLOR = 3'd4;
    do_move(3'd0, 1'b1, 1'b0, 1, 8'd1, 1'b0, 1'b0, "b2b_m1");
    do_move(3'd5, 1'b1, 1'b0, 1, 8'd2, 1'b0, 1'b0, "b2b_m2");
    n_checks++;
    if (exp_fill_q.size() != 0)
      $display("FAIL fills_outstanding: got %0d expected 0", exp_fill_q.size());
    else
      n_pass++;
  endtask

  initial begin
    tick();
    test_reset();
    test_begin();
    test_legal_fill();
    test_illegal();
    test_lost();
    test_won();
    test_zero_budget();
    test_timeout();
    test_reset_mid_fill();
    test_begin_during_fill();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
